// File: rtl/riscv_writeback.sv
// Writeback stage: merges ALU results and formatted LSU loads onto the single register-file write port.
// Optional RISCV_WB_PERF_EN macro adds saturating stall and dropped-load counters.
module riscv_writeback #(
    parameter bit SUPPORT_LOAD_BYPASS = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        alu_valid_i,
    input  logic [4:0]  alu_rd_i,
    input  logic [31:0] alu_value_i,
    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic [4:0]  lsu_rd_i,
    input  logic [31:0] lsu_data_i,
    input  logic [1:0]  lsu_addr_i,
    input  logic [1:0]  lsu_size_i,
    input  logic        lsu_signed_i,
    output logic [4:0]  rd0_o,
    output logic [31:0] rd0_value_o,
    output logic        wb_pending_o,
    output logic [4:0]  wb_pending_rd_o
`ifdef RISCV_WB_PERF_EN
    ,
    output logic [31:0] stall_cycles_o,
    output logic [15:0] drop_count_o
`endif
);

    localparam int unsigned REG_W  = 5;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned BYTE_W = 8;

    logic              hold_valid_q, hold_valid_d;
    logic [REG_W-1:0]  hold_rd_q, hold_rd_d;
    logic [XLEN-1:0]   hold_value_q, hold_value_d;
    logic [REG_W-1:0]  rd0_d;
    logic [XLEN-1:0]   rd0_value_d;

    logic              alu_act;
    logic              lsu_acc;
    logic              lsu_drop;
    logic              hold_drop;
    logic              load_keep;
    logic [BYTE_W-1:0] byte_lane;
    logic [HALF_W-1:0] half_lane;
    logic [XLEN-1:0]   load_value;

    // Ready depends only on the holding register, forced low during reset.
    assign lsu_ready_o     = rst_i & ~hold_valid_q;
    assign wb_pending_o    = hold_valid_q;
    assign wb_pending_rd_o = hold_rd_q;

    assign alu_act   = alu_valid_i && (alu_rd_i != '0);
    assign lsu_acc   = lsu_valid_i && lsu_ready_o;
    assign lsu_drop  = lsu_acc && ((lsu_rd_i == '0) || (alu_act && (alu_rd_i == lsu_rd_i)));
    assign hold_drop = hold_valid_q && alu_act && (alu_rd_i == hold_rd_q);
    assign load_keep = lsu_acc && !lsu_drop;

    // Lane extraction and sign/zero extension of the raw load word.
    always_comb begin
        unique case (lsu_addr_i)
            2'd0:    byte_lane = lsu_data_i[7:0];
            2'd1:    byte_lane = lsu_data_i[15:8];
            2'd2:    byte_lane = lsu_data_i[23:16];
            default: byte_lane = lsu_data_i[31:24];
        endcase
        half_lane = lsu_addr_i[1] ? lsu_data_i[31:16] : lsu_data_i[15:0];
        unique case (lsu_size_i)
            2'd0:    load_value = {{(XLEN-BYTE_W){lsu_signed_i & byte_lane[BYTE_W-1]}}, byte_lane};
            2'd1:    load_value = {{(XLEN-HALF_W){lsu_signed_i & half_lane[HALF_W-1]}}, half_lane};
            default: load_value = lsu_data_i;
        endcase
    end

    // Port arbitration: ALU, then held load, then bypassed load.
    always_comb begin
        rd0_d        = '0;
        rd0_value_d  = '0;
        hold_valid_d = hold_valid_q;
        hold_rd_d    = hold_rd_q;
        hold_value_d = hold_value_q;
        if (alu_act) begin
            rd0_d       = alu_rd_i;
            rd0_value_d = alu_value_i;
            if (hold_drop) begin
                hold_valid_d = 1'b0;
                hold_rd_d    = '0;
                hold_value_d = '0;
            end
            if (load_keep) begin
                hold_valid_d = 1'b1;
                hold_rd_d    = lsu_rd_i;
                hold_value_d = load_value;
            end
        end else if (hold_valid_q) begin
            rd0_d        = hold_rd_q;
            rd0_value_d  = hold_value_q;
            hold_valid_d = 1'b0;
            hold_rd_d    = '0;
            hold_value_d = '0;
        end else if (load_keep) begin
            if (SUPPORT_LOAD_BYPASS) begin
                rd0_d       = lsu_rd_i;
                rd0_value_d = load_value;
            end else begin
                hold_valid_d = 1'b1;
                hold_rd_d    = lsu_rd_i;
                hold_value_d = load_value;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rd0_o        <= '0;
            rd0_value_o  <= '0;
            hold_valid_q <= 1'b0;
            hold_rd_q    <= '0;
            hold_value_q <= '0;
        end else begin
            rd0_o        <= rd0_d;
            rd0_value_o  <= rd0_value_d;
            hold_valid_q <= hold_valid_d;
            hold_rd_q    <= hold_rd_d;
            hold_value_q <= hold_value_d;
        end
    end

`ifdef RISCV_WB_PERF_EN
    // Saturating performance counters.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cycles_o <= '0;
            drop_count_o   <= '0;
        end else begin
            if (lsu_valid_i && !lsu_ready_o && (stall_cycles_o != '1))
                stall_cycles_o <= stall_cycles_o + 32'd1;
            if ((lsu_drop || hold_drop) && (drop_count_o != '1))
                drop_count_o <= drop_count_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_riscv_writeback.sv
// Directed self-checking bench for riscv_writeback (default build, load bypass enabled).
// Perf-counter checks are compiled in when RISCV_WB_PERF_EN is defined.
module tb_riscv_writeback;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        alu_valid_i;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_value_i;
    logic        lsu_valid_i;
    logic        lsu_ready_o;
    logic [4:0]  lsu_rd_i;
    logic [31:0] lsu_data_i;
    logic [1:0]  lsu_addr_i;
    logic [1:0]  lsu_size_i;
    logic        lsu_signed_i;
    logic [4:0]  rd0_o;
    logic [31:0] rd0_value_o;
    logic        wb_pending_o;
    logic [4:0]  wb_pending_rd_o;
`ifdef RISCV_WB_PERF_EN
    logic [31:0] stall_cycles_o;
    logic [15:0] drop_count_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    riscv_writeback #(.SUPPORT_LOAD_BYPASS(1'b1)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .alu_valid_i    (alu_valid_i),
        .alu_rd_i       (alu_rd_i),
        .alu_value_i    (alu_value_i),
        .lsu_valid_i    (lsu_valid_i),
        .lsu_ready_o    (lsu_ready_o),
        .lsu_rd_i       (lsu_rd_i),
        .lsu_data_i     (lsu_data_i),
        .lsu_addr_i     (lsu_addr_i),
        .lsu_size_i     (lsu_size_i),
        .lsu_signed_i   (lsu_signed_i),
        .rd0_o          (rd0_o),
        .rd0_value_o    (rd0_value_o),
        .wb_pending_o   (wb_pending_o),
        .wb_pending_rd_o(wb_pending_rd_o)
`ifdef RISCV_WB_PERF_EN
        ,
        .stall_cycles_o (stall_cycles_o),
        .drop_count_o   (drop_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid_i  = 1'b0;
        alu_rd_i     = '0;
        alu_value_i  = '0;
        lsu_valid_i  = 1'b0;
        lsu_rd_i     = '0;
        lsu_data_i   = '0;
        lsu_addr_i   = '0;
        lsu_size_i   = '0;
        lsu_signed_i = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [31:0] data, input logic [1:0] size,
                            input logic [1:0] addr, input logic sgn);
        lsu_valid_i  = 1'b1;
        lsu_rd_i     = rd;
        lsu_data_i   = data;
        lsu_size_i   = size;
        lsu_addr_i   = addr;
        lsu_signed_i = sgn;
    endtask

    task automatic set_alu(input logic [4:0] rd, input logic [31:0] val);
        alu_valid_i = 1'b1;
        alu_rd_i    = rd;
        alu_value_i = val;
    endtask

    logic [1:0]  ld_size [6];
    logic [1:0]  ld_addr [6];
    logic        ld_sgn  [6];
    logic [31:0] ld_exp  [6];

    initial begin
        ld_size[0] = 2'd0; ld_addr[0] = 2'd3; ld_sgn[0] = 1'b1; ld_exp[0] = 32'hFFFF_FF80;
        ld_size[1] = 2'd1; ld_addr[1] = 2'd2; ld_sgn[1] = 1'b0; ld_exp[1] = 32'h0000_80FF;
        ld_size[2] = 2'd2; ld_addr[2] = 2'd0; ld_sgn[2] = 1'b1; ld_exp[2] = 32'h80FF_7F01;
        ld_size[3] = 2'd0; ld_addr[3] = 2'd1; ld_sgn[3] = 1'b1; ld_exp[3] = 32'h0000_007F;
        ld_size[4] = 2'd1; ld_addr[4] = 2'd3; ld_sgn[4] = 1'b1; ld_exp[4] = 32'hFFFF_80FF;
        ld_size[5] = 2'd3; ld_addr[5] = 2'd1; ld_sgn[5] = 1'b0; ld_exp[5] = 32'h80FF_7F01;

        rst_i = 1'b0;
        idle_inputs();
        step();
        step();
        check_eq("reset_rd0", 32'(rd0_o), 32'd0);
        check_eq("reset_value", rd0_value_o, 32'd0);
        check_eq("reset_pending", 32'(wb_pending_o), 32'd0);
        check_eq("reset_pending_rd", 32'(wb_pending_rd_o), 32'd0);
        check_eq("reset_ready_low", 32'(lsu_ready_o), 32'd0);
        rst_i = 1'b1;
        #1;
        check_eq("ready_after_reset", 32'(lsu_ready_o), 32'd1);

        // ALU only, then idle, then alu rd 0 treated as idle
        set_alu(5'd5, 32'h1234);
        step();
        check_eq("alu_rd", 32'(rd0_o), 32'd5);
        check_eq("alu_value", rd0_value_o, 32'h1234);
        idle_inputs();
        step();
        check_eq("alu_idle_rd", 32'(rd0_o), 32'd0);
        set_alu(5'd0, 32'hDEAD);
        step();
        check_eq("alu_rd0_nowrite", 32'(rd0_o), 32'd0);
        idle_inputs();

        // Load formatting with bypass, each load alone
        for (int i = 0; i < 6; i++) begin
            set_load(5'(10 + i), 32'h80FF_7F01, ld_size[i], ld_addr[i], ld_sgn[i]);
            step();
            idle_inputs();
            check_eq($sformatf("load%0d_rd", i), 32'(rd0_o), 32'(10 + i));
            check_eq($sformatf("load%0d_value", i), rd0_value_o, ld_exp[i]);
            check_eq($sformatf("load%0d_nohold", i), 32'(wb_pending_o), 32'd0);
        end

        // Collision: ALU wins, load held one cycle
        set_alu(5'd3, 32'hA);
        set_load(5'd4, 32'hB, 2'd2, 2'd0, 1'b0);
        step();
        idle_inputs();
        check_eq("coll_alu_rd", 32'(rd0_o), 32'd3);
        check_eq("coll_alu_value", rd0_value_o, 32'hA);
        check_eq("coll_pending", 32'(wb_pending_o), 32'd1);
        check_eq("coll_pending_rd", 32'(wb_pending_rd_o), 32'd4);
        check_eq("coll_ready_low", 32'(lsu_ready_o), 32'd0);
        step();
        check_eq("coll_load_rd", 32'(rd0_o), 32'd4);
        check_eq("coll_load_value", rd0_value_o, 32'hB);
        check_eq("coll_drained", 32'(wb_pending_o), 32'd0);
        check_eq("coll_ready_back", 32'(lsu_ready_o), 32'd1);

        // WAW: held rd 7 overwritten by younger ALU write
        set_alu(5'd1, 32'h11);
        set_load(5'd7, 32'h77, 2'd2, 2'd0, 1'b0);
        step();
        idle_inputs();
        check_eq("waw_setup_pending_rd", 32'(wb_pending_rd_o), 32'd7);
        set_alu(5'd7, 32'h55);
        step();
        idle_inputs();
        check_eq("waw_alu_rd", 32'(rd0_o), 32'd7);
        check_eq("waw_alu_value", rd0_value_o, 32'h55);
        check_eq("waw_hold_cleared", 32'(wb_pending_o), 32'd0);
        step();
        check_eq("waw_no_load_write", 32'(rd0_o), 32'd0);
`ifdef RISCV_WB_PERF_EN
        check_eq("waw_drop_count", 32'(drop_count_o), 32'd1);
`endif

        // Load to x0 accepted and dropped
        set_load(5'd0, 32'h1234_5678, 2'd2, 2'd0, 1'b0);
        #1;
        check_eq("x0_ready", 32'(lsu_ready_o), 32'd1);
        step();
        idle_inputs();
        check_eq("x0_no_write", 32'(rd0_o), 32'd0);
        check_eq("x0_no_hold", 32'(wb_pending_o), 32'd0);
`ifdef RISCV_WB_PERF_EN
        check_eq("x0_drop_count", 32'(drop_count_o), 32'd2);
`endif

        // Back-pressure: hold full while ALU busy for three cycles
        set_alu(5'd2, 32'h22);
        set_load(5'd9, 32'h99, 2'd2, 2'd0, 1'b0);
        step();
        check_eq("bp_first_rd", 32'(rd0_o), 32'd2);
        set_load(5'd14, 32'hEE, 2'd2, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            set_alu(5'(11 + i), 32'(32'h100 + i));
            #1;
            check_eq($sformatf("bp_ready_low%0d", i), 32'(lsu_ready_o), 32'd0);
            step();
            check_eq($sformatf("bp_alu_rd%0d", i), 32'(rd0_o), 32'(11 + i));
            check_eq($sformatf("bp_pending%0d", i), 32'(wb_pending_rd_o), 32'd9);
        end
        alu_valid_i = 1'b0;
        alu_rd_i    = '0;
        step();
        check_eq("bp_drain_rd", 32'(rd0_o), 32'd9);
        check_eq("bp_drain_value", rd0_value_o, 32'h99);
        check_eq("bp_ready_back", 32'(lsu_ready_o), 32'd1);
        step();
        idle_inputs();
        check_eq("bp_next_load_rd", 32'(rd0_o), 32'd14);
        check_eq("bp_next_load_value", rd0_value_o, 32'hEE);
`ifdef RISCV_WB_PERF_EN
        check_eq("bp_stall_cycles", stall_cycles_o, 32'd4);
`endif

        // Reset while a load is held
        set_alu(5'd20, 32'h1);
        set_load(5'd21, 32'h2, 2'd2, 2'd0, 1'b0);
        step();
        idle_inputs();
        check_eq("rst_hold_setup", 32'(wb_pending_o), 32'd1);
        rst_i = 1'b0;
        step();
        check_eq("rst_mid_rd0", 32'(rd0_o), 32'd0);
        check_eq("rst_mid_pending", 32'(wb_pending_o), 32'd0);
        check_eq("rst_mid_pending_rd", 32'(wb_pending_rd_o), 32'd0);
        check_eq("rst_mid_ready", 32'(lsu_ready_o), 32'd0);
`ifdef RISCV_WB_PERF_EN
        check_eq("rst_stall_clear", stall_cycles_o, 32'd0);
        check_eq("rst_drop_clear", 32'(drop_count_o), 32'd0);
`endif
        rst_i = 1'b1;
        step();
        check_eq("rst_post_rd0_a", 32'(rd0_o), 32'd0);
        step();
        check_eq("rst_post_rd0_b", 32'(rd0_o), 32'd0);
        check_eq("rst_post_ready", 32'(lsu_ready_o), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/riscv_writeback.md
Name: riscv_writeback

Overview:
- Writeback stage directly upstream of the integer register file.
- Merges two result sources into the register file's single write port (rd0 index and value):
  - the single-cycle ALU/execute result;
  - the multi-cycle load/store unit (LSU) return, which is aligned and sign/zero-extended here.
- Has one holding entry to absorb collisions.
- Exports pending-load state to the issue stage for hazard stalls.

Parameters:
- SUPPORT_LOAD_BYPASS, 1: 1 = an accepted load with no ALU collision is written the same cycle; 0 = every load passes through the holding entry (+1 cycle).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- alu_valid_i  in  1  ALU result valid; never back-pressured.
- alu_rd_i  in  5  ALU destination register.
- alu_value_i  in  32  ALU result.
- lsu_valid_i  in  1  load data valid.
- lsu_ready_o  out  1  load data accepted when valid and ready are both 1.
- lsu_rd_i  in  5  load destination register.
- lsu_data_i  in  32  raw aligned-word read data.
- lsu_addr_i  in  2  byte offset of the load address.
- lsu_size_i  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- lsu_signed_i  in  1  1 = sign-extend, 0 = zero-extend.
- rd0_o  out  5  register file write index; 0 = no write.
- rd0_value_o  out  32  register file write data.
- wb_pending_o  out  1  holding entry occupied.
- wb_pending_rd_o  out  5  rd of the held load; 0 when empty.

Behaviour:
- Reset (rst_i = 0 at a rising edge): rd0_o = 0, rd0_value_o = 0, holding entry cleared, wb_pending_o = 0, wb_pending_rd_o = 0. lsu_ready_o = 0 while rst_i = 0.
- Outputs rd0_o and rd0_value_o are registered: a selected source appears on them the cycle after selection. Latency is 1 cycle for ALU and bypassed loads, 2 cycles for held loads.
- Ready: lsu_ready_o = !hold_valid, taken from the register (no combinational path from valid inputs).
- Load formatting:
  - Byte: lane = lsu_data_i >> (8 × lsu_addr_i), then [7:0].
  - Half: lane = lsu_addr_i[1] ? [31:16] : [15:0]; lsu_addr_i[0] ignored (misalignment is trapped upstream).
  - Word: lsu_data_i passed unchanged.
  - Byte and half are extended per lsu_signed_i.
  - Formatting is applied on acceptance; the holding entry stores the formatted value.
- An ALU write counts as active when alu_valid_i = 1 and alu_rd_i ≠ 0.
- Per-cycle selection, highest priority first:
  1. Active ALU write → drive ALU.
  2. Else hold_valid → drive held entry; hold clears.
  3. Else load accepted and SUPPORT_LOAD_BYPASS = 1 → drive formatted load directly.
  4. Else → rd0_o = 0 next cycle.
- An accepted load that is not driven this cycle is captured into the holding entry.
- ALU is always younger than any outstanding or same-cycle load. If an active ALU write targets the same rd as the held entry, or as a load accepted that cycle, the load result is dropped (WAW). A dropped load is not written and does not occupy hold.
- A load with lsu_rd_i = 0 is accepted, counted as a drop (no hold, no write).
- Hold full + ALU active every cycle: hold waits, lsu_ready_o stays 0. There is no starvation guarantee; the issue stage must bound this.
- alu_valid_i = 1 with alu_rd_i = 0: no write, treated as idle (the hold may drain).
- Hold occupancy is exactly 0 or 1, so there is no overflow case.
- Reset asserted mid-hold: the held entry is discarded without being written.

Optional Feature:
- Macro: RISCV_WB_PERF_EN.
- Defined:
  - Adds output stall_cycles_o [31:0], which counts cycles with lsu_valid_i = 1 and lsu_ready_o = 0.
  - Adds output drop_count_o [15:0], which counts dropped loads (WAW drops and rd = 0 loads).
  - Both counters saturate at all-ones and clear on reset.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- ALU only: alu_valid_i = 1, alu_rd_i = 5, alu_value_i = 0x1234 → next cycle rd0_o = 5, rd0_value_o = 0x1234; idle cycle after → rd0_o = 0.
- Load formatting, each load alone with SUPPORT_LOAD_BYPASS = 1 and lsu_data_i = 0x80FF7F01:
  - Byte, addr 3, signed → 0xFFFFFF80.
  - Half, addr 2, unsigned → 0x000080FF.
  - Word → 0x80FF7F01.
  - Each appears 1 cycle after acceptance.
- Collision: same cycle ALU rd 3 = 0xA and load rd 4 = 0xB → cycle+1 writes rd 3; wb_pending_o = 1 with wb_pending_rd_o = 4 and lsu_ready_o = 0; cycle+2 writes rd 4 = 0xB; ready returns to 1.
- WAW drop: load rd 7 held, next cycle ALU writes rd 7 = 0x55 → only 0x55 is written, hold clears, no rd 7 load write follows; with RISCV_WB_PERF_EN defined, drop_count_o = 1.
- Back-pressure: hold full, ALU active for 3 cycles, lsu_valid_i = 1 throughout → lsu_ready_o = 0 for those cycles; the hold drains on the first idle cycle; with RISCV_WB_PERF_EN defined, stall_cycles_o increments for each cycle lsu_valid_i = 1 while lsu_ready_o = 0.
- Reset mid-operation: hold full, rst_i = 0 for one edge → rd0_o = 0, wb_pending_o = 0, no write of the held value after reset is released.
